// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one upstream port, four downstream slots, per-output beat counters.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface demux4_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic [1:0]           in_sel;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic [3:0]           out_valid;
  logic [4*WIDTH-1:0]   out_data;
  logic [3:0]           out_ready;
  logic [4*CNT_W-1:0]   beat_cnt;

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  beat_cnt
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output beat_cnt
  );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer with one holding register per output and per-output delivered-beat counters.
// Optional macro DEMUX4_ASSERT_EN compiles in protocol/integrity assertions.
module demux4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  demux4_stream_if.slave       bus
);

  logic [3:0]                vld_q, vld_d;
  logic [3:0][WIDTH-1:0]     data_q, data_d;
  logic [3:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]                pop;
  logic [3:0]                load;
  logic                      accept;
  logic                      in_ready;

  // A slot can take a new beat when empty or when it is being drained this same cycle.
  assign in_ready = !vld_q[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    pop    = '0;
    load   = '0;
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 4; i++) begin
      pop[i]  = vld_q[i] && bus.out_ready[i];
      load[i] = accept && (bus.in_sel == 2'(i));
      vld_d[i] = load[i] || (vld_q[i] && !pop[i]);
      if (load[i]) begin
        data_d[i] = bus.in_data;
      end
      if (pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Slot registers and counters; reset wins over any same-cycle accept or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.beat_cnt  = cnt_q;

`ifdef DEMUX4_ASSERT_EN
  logic [3:0]            stall_q;
  logic [3:0][WIDTH-1:0] hold_q;

  // Remember which slots were stalled going into the previous edge so the data can be compared after it.
  always_ff @(posedge clk) begin
    stall_q <= rst ? 4'b0000 : (vld_q & ~bus.out_ready);
    hold_q  <= data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.in_valid && $isunknown(bus.in_sel)))
        else $error("[%0t] demux4_stream: in_sel unknown while in_valid", $time);
      for (int i = 0; i < 4; i++) begin
        assert (!stall_q[i] || (data_q[i] == hold_q[i]))
          else $error("[%0t] demux4_stream: slot %0d data changed while stalled", $time, i);
      end
      assert ($onehot0(load) && ((load == 4'b0000) || (load == (4'b0001 << bus.in_sel))))
        else $error("[%0t] demux4_stream: illegal slot load pattern %b", $time, load);
    end
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream (WIDTH=8, CNT_W=4 so counter wrap is reachable quickly).
module tb_demux4_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   total  = 0;

  demux4_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] slice(input int i);
    return bus.out_data[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_beat_cnt",  32'(bus.beat_cnt),  32'h0);
    chk("rst_out_data",  bus.out_data,       32'h0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1 chk($sformatf("post_rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'h1);
    end

    // Single beat to slot 2, consumer stalled
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'hA5; bus.out_ready = 4'b0000;
    step();
    bus.in_valid = 1'b0;
    chk("load2_out_valid", 32'(bus.out_valid), 32'h4);
    chk("load2_slice2",    32'(slice(2)),      32'hA5);
    bus.in_sel = 2'd2;
    #1 chk("full2_in_ready_sel2", 32'(bus.in_ready), 32'h0);
    bus.in_sel = 2'd0;
    #1 chk("full2_in_ready_sel0", 32'(bus.in_ready), 32'h1);

    // Other slot accepted while slot 2 blocked
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h3C;
    #1 chk("sel1_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    chk("load1_out_valid", 32'(bus.out_valid), 32'h6);
    chk("load1_slice2",    32'(slice(2)),      32'hA5);
    chk("load1_slice1",    32'(slice(1)),      32'h3C);

    // Beat to stalled slot 2 is refused and slot data holds
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'h77;
    #1 chk("stall2_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk("stall2_slice2",    32'(slice(2)),      32'hA5);
    chk("stall2_out_valid", 32'(bus.out_valid), 32'h6);

    // Pop slot 1 alone
    bus.out_ready = 4'b0010;
    step();
    bus.out_ready = 4'b0000;
    chk("pop1_out_valid", 32'(bus.out_valid), 32'h4);
    chk("pop1_beat_cnt",  32'(bus.beat_cnt),  32'h0010);

    // Fill slot 0 then stream 4 beats through it at full rate
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h10;
    step();
    chk("fill0_out_valid", 32'(bus.out_valid), 32'h5);
    bus.out_ready = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = 8'(8'h11 + k);
      #1 chk($sformatf("stream0_in_ready_%0d", k), 32'(bus.in_ready), 32'h1);
      chk($sformatf("stream0_slice0_%0d", k), 32'(slice(0)), 32'(8'h10 + k));
      step();
    end
    bus.in_valid = 1'b0;
    chk("stream0_out_valid", 32'(bus.out_valid), 32'h5);
    chk("stream0_slice0",    32'(slice(0)),      32'h14);
    chk("stream0_beat_cnt",  32'(bus.beat_cnt),  32'h0014);
    step();
    bus.out_ready = 4'b0000;
    chk("drain0_out_valid", 32'(bus.out_valid), 32'h4);
    chk("drain0_beat_cnt",  32'(bus.beat_cnt),  32'h0015);

    // All slots full, four concurrent pops plus a reload of slot 2
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0; bus.in_data = 8'h21; step();
    bus.in_sel = 2'd1; bus.in_data = 8'h22; step();
    bus.in_sel = 2'd3; bus.in_data = 8'h23; step();
    chk("allfull_out_valid", 32'(bus.out_valid), 32'hF);
    bus.in_sel = 2'd2; bus.in_data = 8'h99; bus.out_ready = 4'b1111;
    #1 chk("allpop_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    chk("allpop_out_valid", 32'(bus.out_valid), 32'h4);
    chk("allpop_slice2",    32'(slice(2)),      32'h99);
    chk("allpop_beat_cnt",  32'(bus.beat_cnt),  32'h1126);

    // Reset with slots full and traffic in flight
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0; bus.in_data = 8'h31; step();
    bus.in_sel = 2'd3; bus.in_data = 8'h33; step();
    chk("prerst_out_valid", 32'(bus.out_valid), 32'hD);
    rst = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h55; bus.out_ready = 4'b1111;
    step();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_beat_cnt",  32'(bus.beat_cnt),  32'h0);
    chk("midrst_out_data",  bus.out_data,       32'h0);
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1 chk($sformatf("midrst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'h1);
    end

    // 17 pops on output 3 wrap a 4-bit counter to 1
    bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.out_ready = 4'b1000;
    for (int k = 0; k < 17; k++) begin
      bus.in_data = 8'(k);
      step();
    end
    bus.in_valid = 1'b0;
    chk("wrap_last_slice3", 32'(slice(3)), 32'h10);
    step();
    bus.out_ready = 4'b0000;
    chk("wrap_out_valid", 32'(bus.out_valid), 32'h0);
    chk("wrap_beat_cnt",  32'(bus.beat_cnt),  32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
